// File: rtl/vpu_sram_read_arbiter_if.sv
// Port-side and bank-side signal bundle for vpu_sram_read_arbiter.
// "slave" is the arbiter's view; "master" is the VPU and bank-macro side.
interface vpu_sram_read_arbiter_if #(
    parameter int SRAM_READ_PORT_CNT  = 3,
    parameter int SRAM_BANK_CNT       = 4,
    parameter int SRAM_BANK_CNT_LG2   = 2,
    parameter int SRAM_BANK_DEPTH_LG2 = 10,
    parameter int SRAM_DATA_WIDTH     = 512
);
    localparam int P    = SRAM_READ_PORT_CNT;
    localparam int B    = SRAM_BANK_CNT;
    localparam int LG2  = SRAM_BANK_CNT_LG2;
    localparam int DLG2 = SRAM_BANK_DEPTH_LG2;
    localparam int DW   = SRAM_DATA_WIDTH;

    logic [P-1:0]      rreq_i;
    logic [P*LG2-1:0]  rid_i;
    logic [P*DLG2-1:0] raddr_i;
    logic [P-1:0]      reb_i;
    logic [P-1:0]      rlast_i;
    logic [P-1:0]      rack_o;
    logic [P*DW-1:0]   rdata_o;
    logic [P-1:0]      rvalid_o;
    logic [B-1:0]      bank_ren_o;
    logic [B*DLG2-1:0] bank_raddr_o;
    logic [B*DW-1:0]   bank_rdata_i;

    modport slave (
        input  rreq_i, rid_i, raddr_i, reb_i, rlast_i, bank_rdata_i,
        output rack_o, rdata_o, rvalid_o, bank_ren_o, bank_raddr_o
    );

    modport master (
        output rreq_i, rid_i, raddr_i, reb_i, rlast_i, bank_rdata_i,
        input  rack_o, rdata_o, rvalid_o, bank_ren_o, bank_raddr_o
    );
endinterface

// File: rtl/vpu_sram_read_arbiter.sv
// Per-bank round-robin arbiter locking single-read-port SRAM banks to VPU read ports for a burst.
// Optional stall counter output stall_cnt_o enabled by defining VPU_SRAM_ARB_STALL_CNT_EN.
module vpu_sram_read_arbiter #(
    parameter int SRAM_READ_PORT_CNT  = 3,
    parameter int SRAM_BANK_CNT       = 4,
    parameter int SRAM_BANK_CNT_LG2   = 2,
    parameter int SRAM_BANK_DEPTH_LG2 = 10,
    parameter int SRAM_DATA_WIDTH     = 512
) (
    input  logic                   clk,
    input  logic                   rst,
    vpu_sram_read_arbiter_if.slave bus
`ifdef VPU_SRAM_ARB_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cnt_o
`endif
);
    localparam int P    = SRAM_READ_PORT_CNT;
    localparam int B    = SRAM_BANK_CNT;
    localparam int LG2  = SRAM_BANK_CNT_LG2;
    localparam int DLG2 = SRAM_BANK_DEPTH_LG2;
    localparam int DW   = SRAM_DATA_WIDTH;
    localparam int PW   = (P > 1) ? $clog2(P) : 1;

    // GRANT is the first locked cycle (rack pulse); BUSY is the rest of the burst.
    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_BUSY} bank_state_e;

    bank_state_e    state_q    [B];
    bank_state_e    state_d    [B];
    logic [PW-1:0]  owner_q    [B];
    logic [PW-1:0]  owner_d    [B];
    logic [PW-1:0]  rr_ptr_q   [B];
    logic [PW-1:0]  rr_ptr_d   [B];
    logic [P-1:0]   tag_valid_q;
    logic [P-1:0]   tag_valid_d;
    logic [LG2-1:0] tag_bank_q [P];
    logic [LG2-1:0] tag_bank_d [P];
    logic [P-1:0]   locked;
    logic [LG2-1:0] lock_bank  [P];

    always_comb begin
        locked = '0;
        for (int p = 0; p < P; p++) lock_bank[p] = '0;
        for (int b = 0; b < B; b++) begin
            if (state_q[b] != ST_IDLE) begin
                locked[owner_q[b]]    = 1'b1;
                lock_bank[owner_q[b]] = LG2'(b);
            end
        end
    end

    always_comb begin
        logic found;
        int   cand;
        // NOTE: every output of this block gets a default first so no path can leave one unassigned (no latch).
        found             = 1'b0;
        cand              = 0;
        bus.rack_o        = '0;
        bus.bank_ren_o    = '0;
        bus.bank_raddr_o  = '0;
        for (int b = 0; b < B; b++) begin
            state_d[b]  = state_q[b];
            owner_d[b]  = owner_q[b];
            rr_ptr_d[b] = rr_ptr_q[b];
            case (state_q[b])
                ST_IDLE: begin
                    // NOTE: 'found' is a blocking temporary so the first hit from rr_ptr wins within this pass.
                    found = 1'b0;
                    for (int i = 0; i < P; i++) begin
                        cand = (int'(rr_ptr_q[b]) + i) % P;
                        if (!found && bus.rreq_i[cand] && !locked[cand] &&
                            bus.rid_i[cand*LG2 +: LG2] == LG2'(b)) begin
                            found       = 1'b1;
                            owner_d[b]  = PW'(cand);
                            rr_ptr_d[b] = PW'((cand + 1) % P);
                            state_d[b]  = ST_GRANT;
                        end
                    end
                end
                default: begin
                    if (state_q[b] == ST_GRANT) bus.rack_o[owner_q[b]] = 1'b1;
                    state_d[b] = ST_BUSY;
                    if (bus.reb_i[owner_q[b]]) begin
                        bus.bank_ren_o[b]                 = 1'b1;
                        bus.bank_raddr_o[b*DLG2 +: DLG2]  = bus.raddr_i[int'(owner_q[b])*DLG2 +: DLG2];
                        if (bus.rlast_i[owner_q[b]]) state_d[b] = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Return tags follow the beat, not the lock, so the rlast beat still routes after release.
    always_comb begin
        for (int p = 0; p < P; p++) begin
            tag_valid_d[p] = locked[p] & bus.reb_i[p];
            tag_bank_d[p]  = lock_bank[p];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: all state here is a handful of control flops, so every one is reset (no RAM arrays involved).
            for (int b = 0; b < B; b++) begin
                state_q[b]  <= ST_IDLE;
                owner_q[b]  <= '0;
                rr_ptr_q[b] <= '0;
            end
            tag_valid_q <= '0;
            for (int p = 0; p < P; p++) tag_bank_q[p] <= '0;
        end else begin
            for (int b = 0; b < B; b++) begin
                state_q[b]  <= state_d[b];
                owner_q[b]  <= owner_d[b];
                rr_ptr_q[b] <= rr_ptr_d[b];
            end
            tag_valid_q <= tag_valid_d;
            for (int p = 0; p < P; p++) tag_bank_q[p] <= tag_bank_d[p];
        end
    end

    always_comb begin
        bus.rvalid_o = tag_valid_q;
        bus.rdata_o  = '0;
        for (int p = 0; p < P; p++) begin
            if (tag_valid_q[p]) bus.rdata_o[p*DW +: DW] = bus.bank_rdata_i[int'(tag_bank_q[p])*DW +: DW];
        end
    end

`ifdef VPU_SRAM_ARB_STALL_CNT_EN
    logic [P-1:0] granted;
    logic [31:0]  stall_cnt_q;
    logic [31:0]  stall_cnt_d;

    // One count per waiting unlocked port per cycle; the port picked this cycle is not waiting.
    always_comb begin
        logic [32:0] sum;
        granted = '0;
        for (int b = 0; b < B; b++) begin
            if (state_q[b] == ST_IDLE && state_d[b] == ST_GRANT) granted[owner_d[b]] = 1'b1;
        end
        sum = {1'b0, stall_cnt_q};
        for (int p = 0; p < P; p++) sum = sum + 33'(bus.rreq_i[p] & ~locked[p] & ~granted[p]);
        stall_cnt_d = sum[32] ? '1 : sum[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif
endmodule
